// File: rtl/video_fetch_scheduler_if.sv
// Single-word read port shared by the video fetch scheduler and system memory.
interface video_fetch_scheduler_if #(
  parameter int ADDR_W = 22
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_src;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, mem_src, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_src, output mem_ack);
endinterface

// File: rtl/video_fetch_scheduler.sv
// Arbitrates the memory read port between ICA/DCA control fetches and the two
// pixel-plane FIFOs; one outstanding access, flags control fetch window overruns.
module video_fetch_scheduler #(
  parameter int ADDR_W    = 22,
  parameter int LEVEL_W   = 5,
  parameter int LOW_WATER = 8,
  parameter int ICA_WORDS = 8,
  parameter int DCA_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   new_frame,
  input  logic                   new_line,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic                   plane_a_en,
  input  logic                   plane_b_en,
  input  logic                   dca_en,
  input  logic [ADDR_W-1:0]      vsr_a,
  input  logic [ADDR_W-1:0]      vsr_b,
  input  logic [ADDR_W-1:0]      ica_base,
  input  logic [ADDR_W-1:0]      dca_base,
  input  logic [LEVEL_W-1:0]     a_level,
  input  logic [LEVEL_W-1:0]     b_level,
  video_fetch_scheduler_if.master mem,
  output logic                   ica_overrun,
  output logic                   dca_overrun
);
  localparam int ICW = $clog2(ICA_WORDS + 1);
  localparam int DCW = $clog2(DCA_WORDS + 1);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0, SRC_A = 3'd1, SRC_B = 3'd2, SRC_ICA = 3'd3, SRC_DCA = 3'd4
  } src_t;

  state_t            state_q, state_d;
  src_t              src_q, src_d, grant;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_ica_q, addr_ica_d, addr_dca_q, addr_dca_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, sel_ptr;
  logic [ICW-1:0]    ica_left_q, ica_left_d;
  logic [DCW-1:0]    dca_left_q, dca_left_d;
  logic              rr_b_q, rr_b_d;
  logic              ica_ovr_q, ica_ovr_d, dca_ovr_q, dca_ovr_d;
  logic              hblank_q, vblank_q;
  logic              elig_a, elig_b;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_ica_d = addr_ica_q;
    addr_dca_d = addr_dca_q;
    mem_addr_d = mem_addr_q;
    ica_left_d = ica_left_q;
    dca_left_d = dca_left_q;
    rr_b_d     = rr_b_q;
    ica_ovr_d  = ica_ovr_q;
    dca_ovr_d  = dca_ovr_q;
    sel_ptr    = '0;

    elig_a = plane_a_en && (a_level < LEVEL_W'(LOW_WATER));
    elig_b = plane_b_en && (b_level < LEVEL_W'(LOW_WATER));
    grant  = SRC_NONE;
    if ((ica_left_q != '0) && vblank)                grant = SRC_ICA;
    else if ((dca_left_q != '0) && hblank && !vblank) grant = SRC_DCA;
    else if (elig_a && (!elig_b || !rr_b_q))         grant = SRC_A;
    else if (elig_b)                                 grant = SRC_B;

    case (grant)
      SRC_A:   sel_ptr = addr_a_q;
      SRC_B:   sel_ptr = addr_b_q;
      SRC_ICA: sel_ptr = addr_ica_q;
      SRC_DCA: sel_ptr = addr_dca_q;
      default: sel_ptr = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (grant != SRC_NONE) begin
          state_d    = ST_REQ;
          src_d      = grant;
          mem_addr_d = {sel_ptr[ADDR_W-1:1], 1'b0};
          if (grant == SRC_A) rr_b_d = 1'b1;
          if (grant == SRC_B) rr_b_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
          case (src_q)
            SRC_A:   addr_a_d   = addr_a_q + ADDR_W'(2);
            SRC_B:   addr_b_d   = addr_b_q + ADDR_W'(2);
            SRC_ICA: begin
              addr_ica_d = addr_ica_q + ADDR_W'(2);
              if (ica_left_q != '0) ica_left_d = ica_left_q - ICW'(1);
            end
            SRC_DCA: begin
              addr_dca_d = addr_dca_q + ADDR_W'(2);
              if (dca_left_q != '0) dca_left_d = dca_left_q - DCW'(1);
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Window close, then frame/line reloads, so reloads override any ack update.
    if (hblank_q && !hblank && (dca_left_q != '0)) begin
      dca_ovr_d  = 1'b1;
      dca_left_d = '0;
    end
    if (vblank_q && !vblank && (ica_left_q != '0)) begin
      ica_ovr_d  = 1'b1;
      ica_left_d = '0;
    end
    if (new_frame) begin
      addr_a_d   = vsr_a;
      addr_b_d   = vsr_b;
      addr_ica_d = ica_base;
      addr_dca_d = dca_base;
      ica_left_d = ICW'(ICA_WORDS);
      ica_ovr_d  = 1'b0;
      dca_ovr_d  = 1'b0;
    end
    if (new_line) dca_left_d = (dca_en && !vblank) ? DCW'(DCA_WORDS) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_ica_q <= '0;
      addr_dca_q <= '0;
      mem_addr_q <= '0;
      ica_left_q <= '0;
      dca_left_q <= '0;
      rr_b_q     <= 1'b0;
      ica_ovr_q  <= 1'b0;
      dca_ovr_q  <= 1'b0;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_ica_q <= addr_ica_d;
      addr_dca_q <= addr_dca_d;
      mem_addr_q <= mem_addr_d;
      ica_left_q <= ica_left_d;
      dca_left_q <= dca_left_d;
      rr_b_q     <= rr_b_d;
      ica_ovr_q  <= ica_ovr_d;
      dca_ovr_q  <= dca_ovr_d;
      hblank_q   <= hblank;
      vblank_q   <= vblank;
    end
  end

  assign mem.mem_req  = (state_q == ST_REQ);
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_src  = src_q;
  assign ica_overrun  = ica_ovr_q;
  assign dca_overrun  = dca_ovr_q;
endmodule

// File: tb/tb_video_fetch_scheduler.sv
// Randomized bench for video_fetch_scheduler against a per-cycle behavioural model.
module tb_video_fetch_scheduler;
  localparam int ADDR_W = 22, LEVEL_W = 5, LOW = 8, ICA_N = 8, DCA_N = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic new_frame, new_line, hblank, vblank;
  logic plane_a_en, plane_b_en, dca_en;
  logic [ADDR_W-1:0] vsr_a, vsr_b, ica_base, dca_base;
  logic [LEVEL_W-1:0] a_level, b_level;
  logic ica_overrun, dca_overrun;

  video_fetch_scheduler_if #(.ADDR_W(ADDR_W)) mem_if ();

  video_fetch_scheduler #(
    .ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W), .LOW_WATER(LOW),
    .ICA_WORDS(ICA_N), .DCA_WORDS(DCA_N)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .new_frame(new_frame), .new_line(new_line), .hblank(hblank), .vblank(vblank),
    .plane_a_en(plane_a_en), .plane_b_en(plane_b_en), .dca_en(dca_en),
    .vsr_a(vsr_a), .vsr_b(vsr_b), .ica_base(ica_base), .dca_base(dca_base),
    .a_level(a_level), .b_level(b_level),
    .mem(mem_if.master),
    .ica_overrun(ica_overrun), .dca_overrun(dca_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int ack_lat = 0, wait_cnt = 0;
  bit lvl_rand = 0, spur_en = 0, prev_req = 0;
  int g_src[$];
  logic [ADDR_W-1:0] g_addr[$];

  // Reference model state: pointers indexed by source id, words left for ICA(3)/DCA(4).
  logic [ADDR_W-1:0] m_ptr [1:4];
  int m_left [3:4];
  int m_last, m_src;
  bit m_busy, m_iovr, m_dovr, m_hb, m_vb;
  logic [ADDR_W-1:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 1; i <= 4; i++) m_ptr[i] = '0;
    m_left[3] = 0; m_left[4] = 0;
    m_last = 2; m_src = 0; m_busy = 0; m_addr = '0;
    m_iovr = 0; m_dovr = 0; m_hb = 0; m_vb = 0;
  endfunction

  function automatic int pick();
    bit ea, eb;
    if (m_left[3] != 0 && vblank) return 3;
    if (m_left[4] != 0 && hblank && !vblank) return 4;
    ea = plane_a_en && (int'(a_level) < LOW);
    eb = plane_b_en && (int'(b_level) < LOW);
    if (ea && eb) return (m_last == 1) ? 2 : 1;
    if (ea) return 1;
    if (eb) return 2;
    return 0;
  endfunction

  function automatic void m_step();
    int old_i = m_left[3], old_d = m_left[4], s;
    if (m_busy) begin
      if (mem_if.mem_ack) begin
        m_ptr[m_src] = m_ptr[m_src] + 2;
        if (m_src >= 3 && m_left[m_src] > 0) m_left[m_src]--;
        m_busy = 0; m_src = 0;
      end
    end else begin
      s = pick();
      if (s != 0) begin
        m_busy = 1; m_src = s;
        m_addr = m_ptr[s] & ~ADDR_W'(1);
        if (s <= 2) m_last = s;
      end
    end
    if (m_hb && !hblank && old_d != 0) begin m_dovr = 1; m_left[4] = 0; end
    if (m_vb && !vblank && old_i != 0) begin m_iovr = 1; m_left[3] = 0; end
    if (new_frame) begin
      m_ptr[1] = vsr_a; m_ptr[2] = vsr_b; m_ptr[3] = ica_base; m_ptr[4] = dca_base;
      m_left[3] = ICA_N; m_iovr = 0; m_dovr = 0;
    end
    if (new_line) m_left[4] = (dca_en && !vblank) ? DCA_N : 0;
    m_hb = hblank; m_vb = vblank;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) m_reset(); else m_step();
    #1;
    check("req",  32'(mem_if.mem_req),  32'(m_busy));
    check("src",  32'(mem_if.mem_src),  32'(m_src));
    check("addr", 32'(mem_if.mem_addr), 32'(m_addr));
    check("ovr",  32'({ica_overrun, dca_overrun}), 32'({m_iovr, m_dovr}));
    if (mem_if.mem_req && !prev_req) begin
      g_src.push_back(int'(mem_if.mem_src));
      g_addr.push_back(mem_if.mem_addr);
    end
    prev_req = mem_if.mem_req;
    if (mem_if.mem_ack) mem_if.mem_ack = 1'b0;
    else if (mem_if.mem_req) begin
      if (wait_cnt >= ack_lat) begin mem_if.mem_ack = 1'b1; wait_cnt = 0; end
      else wait_cnt++;
    end else if (spur_en && $urandom_range(0, 7) == 0) mem_if.mem_ack = 1'b1;
    if (lvl_rand) begin
      a_level = LEVEL_W'($urandom_range(0, 15));
      b_level = LEVEL_W'($urandom_range(0, 15));
    end
  endtask

  task automatic run_line(input int hb, input int act);
    new_line = 1'b1; hblank = 1'b1; tick(); new_line = 1'b0;
    repeat (hb - 1) tick();
    hblank = 1'b0;
    repeat (act) tick();
  endtask

  task automatic run_frame(input int vbl, input int lines, input int hb, input int act);
    vblank = 1'b1; new_frame = 1'b1; tick(); new_frame = 1'b0;
    repeat (vbl) run_line(hb, act);
    vblank = 1'b0;
    repeat (lines) run_line(hb, act);
  endtask

  task automatic wait_req_src(input int s);
    int n = 0;
    while (!(mem_if.mem_req && int'(mem_if.mem_src) == s) && n < 300) begin
      tick(); n++;
    end
    check("wait_req", 32'(n < 300), 32'd1);
  endtask

  initial begin
    int cnt_a;
    reset_n = 1'b0; new_frame = 0; new_line = 0; hblank = 0; vblank = 0;
    plane_a_en = 0; plane_b_en = 0; dca_en = 0;
    vsr_a = '0; vsr_b = '0; ica_base = '0; dca_base = '0;
    a_level = '1; b_level = '1; mem_if.mem_ack = 1'b0;
    m_reset();
    repeat (3) tick();
    check("rst_req",  32'(mem_if.mem_req), 32'd0);
    check("rst_src",  32'(mem_if.mem_src), 32'd0);
    check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_ovr",  32'({ica_overrun, dca_overrun}), 32'd0);
    reset_n = 1'b1;

    // ICA burst during vblank, then two active lines of DCA fetches.
    ica_base = 22'h1000; dca_base = 22'h2000; dca_en = 1; ack_lat = 2;
    g_src.delete(); g_addr.delete();
    run_frame(2, 2, 40, 60);
    check("ica_cnt", 32'(g_src.size()), 32'd16);
    if (g_src.size() == 16) begin
      check("ica_first", 32'({g_src[0], g_addr[0]}), 32'({3'd3, 22'h1000}));
      check("ica_last",  32'({g_src[7], g_addr[7]}), 32'({3'd3, 22'h100E}));
      check("dca_l1",    32'({g_src[8], g_addr[8]}), 32'({3'd4, 22'h2000}));
      check("dca_l2",    32'({g_src[15], g_addr[15]}), 32'({3'd4, 22'h200E}));
    end
    check("dca_no_ovr", 32'(dca_overrun), 32'd0);

    // Round-robin with both FIFOs empty, immediate ack, pointer wrapping at the top.
    plane_a_en = 1; plane_b_en = 1; dca_en = 0; a_level = 0; b_level = 0; ack_lat = 0;
    vsr_a = 22'h3FFFFC; vsr_b = 22'h0400;
    vblank = 1; new_frame = 1; tick(); new_frame = 0; vblank = 0;
    repeat (4) tick();
    g_src.delete(); g_addr.delete();
    repeat (24) tick();
    for (int i = 0; i < 3; i++) check("rr_alt", 32'(g_src[i] == g_src[i+1]), 32'd0);

    // Threshold: A at LOW_WATER is never served, then served once below it.
    a_level = 8; b_level = 7;
    g_src.delete(); g_addr.delete();
    repeat (30) tick();
    cnt_a = 0;
    foreach (g_src[i]) if (g_src[i] == 1) cnt_a++;
    check("thr_a_none", 32'(cnt_a), 32'd0);
    a_level = 7;
    wait_req_src(1);

    // Short hblank with slow memory forces a DCA overrun, cleared by the next frame.
    plane_a_en = 0; plane_b_en = 0; dca_en = 1; ack_lat = 4;
    run_frame(1, 2, 5, 30);
    check("dovr_set", 32'(dca_overrun), 32'd1);
    new_frame = 1; tick(); new_frame = 0;
    check("dovr_clr", 32'(dca_overrun), 32'd0);
    repeat (20) tick();

    // new_frame coinciding with a plane-A ack: reload must win.
    vblank = 0; hblank = 0; dca_en = 0; plane_a_en = 1; a_level = 0; ack_lat = 1000;
    repeat (12) tick();
    wait_req_src(1);
    vsr_a = 22'h15550; new_frame = 1; mem_if.mem_ack = 1'b1; wait_cnt = 0;
    tick(); new_frame = 0; ack_lat = 0;
    vblank = 0;
    wait_req_src(1);
    check("nf_ack_addr", 32'(mem_if.mem_addr), 32'h15550);

    // Asynchronous reset in the middle of a request.
    ack_lat = 1000;
    repeat (3) tick();
    wait_req_src(1);
    #3 reset_n = 1'b0;
    #1 check("arst_req", 32'(mem_if.mem_req), 32'd0);
    check("arst_src", 32'(mem_if.mem_src), 32'd0);
    m_reset(); mem_if.mem_ack = 1'b0; wait_cnt = 0;
    repeat (2) tick();
    reset_n = 1'b1;

    // Randomized frames.
    lvl_rand = 1; spur_en = 1;
    for (int f = 0; f < 6; f++) begin
      plane_a_en = 1'($urandom); plane_b_en = 1'($urandom); dca_en = 1'($urandom_range(0, 3) != 0);
      vsr_a = ADDR_W'($urandom); vsr_b = ADDR_W'($urandom);
      ica_base = ADDR_W'($urandom); dca_base = ADDR_W'($urandom);
      ack_lat = $urandom_range(0, 5);
      run_frame($urandom_range(1, 3), $urandom_range(2, 5),
                $urandom_range(4, 30), $urandom_range(10, 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_fetch_scheduler.md
# video_fetch_scheduler

Shares the single system-memory read port between the two pixel-plane FIFOs and the display control-program fetcher (ICA per frame, DCA per line). It is driven by the frame/line strobes and blanking flags of the video timing generator. It issues one single-word read at a time with a req/ack handshake and tags each access with its requester. It also flags control fetches that fail to finish inside their blanking window.

## Interface
- ADDR_W, 22, byte-address width of memory port
- LEVEL_W, 5, width of FIFO level inputs
- LOW_WATER, 8, plane FIFO refill threshold in words
- ICA_WORDS, 8, control words fetched per frame during vblank
- DCA_WORDS, 4, control words fetched per line during hblank

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- new_frame, new_line, hblank, vblank  in  1 each  from video timing, registered strobes/levels
- plane_a_en, plane_b_en, dca_en  in  1 each  fetch enables
- vsr_a, vsr_b, ica_base, dca_base  in  ADDR_W each  start addresses, sampled on new_frame
- a_level, b_level  in  LEVEL_W each  current plane FIFO fill in words
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  word-aligned byte address (bit 0 always 0)
- mem_src  out  3  0 none, 1 plane A, 2 plane B, 3 ICA, 4 DCA
- mem_ack  in  1  one-cycle pulse: read data valid, access done
- ica_overrun, dca_overrun  out  1 each  sticky error flags, cleared on new_frame

## Operation
- Pointers: addr_a, addr_b, addr_ica, addr_dca (ADDR_W). On new_frame: load from vsr_a, vsr_b, ica_base, dca_base. Each ack adds 2 to the pointer of the acked source. Wrap is modulo 2^ADDR_W.
- Counters: ica_left loads ICA_WORDS on new_frame. dca_left loads DCA_WORDS on new_line when dca_en && !vblank, else loads 0. Each ack of the matching source decrements it.
- Eligibility, evaluated in IDLE:
  - ICA: ica_left != 0 && vblank.
  - DCA: dca_left != 0 && hblank && !vblank.
  - Plane X: plane_x_en && level_x < LOW_WATER. Allowed at any time, including vblank, so the first line is prefetched.
- Priority: ICA > DCA > planes. Between A and B: round-robin. The last-granted plane loses a tie. The pointer resets to "A next" on reset.
- FSM:
  - IDLE: if any source is eligible, latch its addr/src and go to REQ. Otherwise stay.
  - REQ: mem_req=1, addr/src held stable. On mem_ack, update pointer/counter and go to IDLE.
  - Minimum 2 cycles per access. No request in the cycle after ack.
- Window close:
  - hblank falls with dca_left != 0 → dca_overrun=1, dca_left=0.
  - vblank falls with ica_left != 0 → ica_overrun=1, ica_left=0.
  - An access already in REQ completes normally. Its ack does not underflow a zeroed counter; the counter saturates at 0.
- new_frame or new_line during REQ: the outstanding access completes to its latched address. The pointer reload takes priority over the ack increment in the same cycle. The counter reload takes priority over the ack decrement.
- A plane disabled while in REQ still completes its access.

## Timing
- Reset (async assert, sync release) sets:
  - mem_req=0, mem_addr=0, mem_src=0
  - overrun flags 0
  - all pointers/counters 0
  - FSM IDLE, RR=A
- Decision latency: an eligible condition true in IDLE at cycle n gives mem_req=1 at cycle n+1.
- mem_ack is sampled only in REQ. An ack while in IDLE is ignored.
- On ack at cycle n: mem_req=0, mem_src=0 at n+1. The earliest next mem_req is n+2.
- mem_addr keeps its last value while idle. mem_src returns to 0.
- Overrun flags set the cycle after the falling blank edge is seen. They clear the cycle after new_frame.
- Level inputs are assumed to already include the word in flight. Only one access is ever outstanding.

## Test plan
- ICA burst: ica_base=0x1000, vblank=1, new_frame, ack 3 cycles after each req → 8 reads at 0x1000..0x100E, src=3. Then plane reads begin.
- DCA per line: dca_base=0x2000, dca_en=1, 2 lines with 40-cycle hblank → line 1 reads 0x2000..0x2006, line 2 reads 0x2008..0x200E, src=4, no overrun.
- DCA overrun: hblank lasting only 5 cycles, ack latency 4 → at most 1 DCA read. dca_overrun=1 after hblank falls. Flag clears after next new_frame.
- Plane round-robin: a_level=b_level=0 held, both enabled, ack immediate → src alternates 1,2,1,2. Addresses step +2 from vsr_a/vsr_b. Gap of exactly 1 idle cycle between accesses.
- Threshold: a_level=8, b_level=7 → only B served. Drop a_level to 7 → A granted at its next IDLE.
- Corner cases:
  - reset_n low mid-REQ → mem_req=0 immediately (async).
  - new_frame coincident with ack of a plane-A read → addr_a=vsr_a (reload wins).
